// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_stage_pkg;

   localparam int unsigned ILEN = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // REQ: may issue a request; WAIT: own response outstanding;
   // DRAIN: a wrong-path response is outstanding and must be swallowed.
   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [31:0]     pc;
      logic [31:0]     pc_plus4;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry buffer of fetched instructions with synchronous flush
module fetch_fifo
   import fetch_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   output logic [1:0]   count_o,
   output logic         valid_o,
   output fetch_entry_t head_o
);

   fetch_entry_t mem_q [2];
   fetch_entry_t mem_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop_i && (count_q != 2'd0);
   assign do_push = push_i && ((count_q != 2'd2) || do_pop);

   // Next-state: flush wins over push and pop, otherwise update pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
         end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
         end
      end
   end

   // State register for storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign valid_o = (count_q != 2'd0);
   assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, one-at-a-time imem requests, redirect flush
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [31:0] redirectPC_i,
   output logic        imemReq_o,
   output logic [31:0] imemAddr_o,
   input  logic        imemGnt_i,
   input  logic        imemRvalid_i,
   input  logic [31:0] imemRdata_i,
   output logic        instrValid_o,
   input  logic        instrReady_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcPlus4_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic         push;
   logic         pop;
   logic         req;
   logic [1:0]   fifo_count;
   logic         fifo_valid;
   fetch_entry_t push_entry;
   fetch_entry_t head;
   logic         unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirectPC_i[1:0];

   // Credit rule: only REQ has nothing outstanding, so a free slot now is a free slot at response time.
   assign req = (state_q == ST_REQ) && (fifo_count <= 2'd1) && !rst;
   assign pop = fifo_valid && instrReady_i;

   // Next-state and push decision; a redirect overrides pc and cancels any push.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      unique case (state_q)
         ST_REQ: begin
            if (req && imemGnt_i) begin
               if (redirect_i) begin
                  state_d = ST_DRAIN;
               end else begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + 32'd4;
                  state_d  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (imemRvalid_i) begin
               push    = !redirect_i;
               state_d = ST_REQ;
            end else if (redirect_i) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (imemRvalid_i) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
      if (redirect_i) begin
         pc_d = word_align(redirectPC_i);
      end
   end

   // Entry captured from the memory response, tagged with the address it was fetched from.
   always_comb begin
      push_entry          = '0;
      push_entry.instr    = imemRdata_i;
      push_entry.pc       = req_pc_q;
      push_entry.pc_plus4 = req_pc_q + 32'd4;
   end

   // FSM, fetch pointer and in-flight address registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   fetch_fifo u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_i),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .count_o     (fifo_count),
      .valid_o     (fifo_valid),
      .head_o      (head)
   );

   assign imemReq_o    = req;
   assign imemAddr_o   = pc_q;
   assign instrValid_o = fifo_valid;
   assign instr_o      = head.instr;
   assign pc_o         = head.pc;
   assign pcPlus4_o    = head.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a variable-latency memory model
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic        instr_valid;
   logic        ready = 1'b0;
   logic [31:0] instr_o, pc_o, pc_plus4_o;

   int          n_tests = 0;
   int          n_fail = 0;
   int          deliveries = 0;
   int          gnt_count = 0;
   int          gnt_mode = 0;
   int          lat_mode = 0;
   int          lat_fixed = 1;
   logic [31:0] exp_q[$];
   logic [31:0] exp_tail;
   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          pend_cnt = 0;

   fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk          (clk),
      .rst          (rst),
      .redirect_i   (redirect_i),
      .redirectPC_i (redirect_pc),
      .imemReq_o    (imem_req),
      .imemAddr_o   (imem_addr),
      .imemGnt_i    (gnt),
      .imemRvalid_i (rvalid),
      .imemRdata_i  (rdata),
      .instrValid_o (instr_valid),
      .instrReady_i (ready),
      .instr_o      (instr_o),
      .pc_o         (pc_o),
      .pcPlus4_o    (pc_plus4_o)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   // Memory: drives response/grant just after the edge; one response per grant after the chosen latency.
   initial forever begin
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      rdata  = 32'h0;
      if (rst) begin
         pend = 1'b0;
      end else if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = ~pend_addr;
            pend   = 1'b0;
         end
      end
      case (gnt_mode)
         0: gnt = 1'b1;
         1: gnt = 1'b0;
         default: gnt = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Memory: capture accepted requests mid-cycle.
   initial forever begin
      @(negedge clk);
      if (!rst && imem_req && gnt) begin
         check("one_outstanding", 32'(pend), 32'd0);
         pend      = 1'b1;
         pend_addr = imem_addr;
         pend_cnt  = (lat_mode != 0) ? int'($urandom_range(1, 5)) : lat_fixed;
         gnt_count++;
      end
   end

   // Monitor: every accepted instruction must match the head of the expected-PC queue.
   initial forever begin
      logic [31:0] e;
      @(negedge clk);
      if (!rst) begin
         if (instr_valid && ready && !redirect_i) begin
            deliveries++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_instr: got pc %h, required no instruction", pc_o);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", pc_o, e);
               check("sb_pc_plus4", pc_plus4_o, e + 32'd4);
               check("sb_instr", instr_o, ~e);
            end
         end else if (!instr_valid) begin
            check("idle_zero", instr_o | pc_o | pc_plus4_o, 32'h0);
         end
      end
   end

   task automatic do_reset();
      next_cycle();
      rst        = 1'b1;
      ready      = 1'b0;
      redirect_i = 1'b0;
      next_cycle();
      sample();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_data", instr_o | pc_o | pc_plus4_o, 32'h0);
      next_cycle();
      rst = 1'b0;
      exp_q.delete();
      gnt_count = 0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int i;
      i = 0;
      sample();
      while (exp_q.size() != 0 && i < budget) begin
         next_cycle();
         sample();
         i++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int tgt;

      // Free run, 1-cycle memory: first request at RESET_PC, outputs on cycles 2, 4, 6.
      lat_mode = 0; lat_fixed = 1; gnt_mode = 0;
      do_reset();
      ready = 1'b1;
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
      sample();
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'h100);
      check("first_valid", 32'(instr_valid), 32'd0);
      for (int i = 1; i <= 6; i++) begin
         next_cycle();
         sample();
         check("rate_valid", 32'(instr_valid), 32'((i % 2) == 0));
      end
      next_cycle();
      ready = 1'b0;
      sample();
      check("free_run_drained", 32'(exp_q.size()), 32'd0);

      // Back-pressure: two buffered, request held low, then released in order.
      do_reset();
      sample();
      for (int i = 1; i <= 9; i++) begin
         next_cycle();
         sample();
         if (i >= 4) check("bp_req_low", 32'(imem_req), 32'd0);
      end
      check("bp_grants", 32'(gnt_count), 32'd2);
      check("bp_head_valid", 32'(instr_valid), 32'd1);
      check("bp_head_pc", pc_o, 32'h100);
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
      next_cycle();
      ready = 1'b1;
      wait_drain("bp_drained", 20);

      // Redirect while waiting for the 0x104 response (3-cycle memory).
      lat_fixed = 3;
      do_reset();
      ready = 1'b1;
      exp_q.push_back(32'h100); exp_q.push_back(32'h200);
      sample();
      for (int i = 1; i <= 9; i++) begin
         next_cycle();
         redirect_i  = (i == 5);
         redirect_pc = 32'h200;
         sample();
         if (i == 5) check("wait_no_req", 32'(imem_req), 32'd0);
         if (i == 6 || i == 7) check("drain_no_req", 32'(imem_req), 32'd0);
         if (i == 8) begin
            check("target_req", 32'(imem_req), 32'd1);
            check("target_addr", imem_addr, 32'h200);
         end
      end
      wait_drain("redir_wait_drained", 30);

      // Redirect coinciding with a grant and a pop.
      lat_fixed = 1;
      do_reset();
      ready = 1'b1;
      exp_q.push_back(32'h300);
      sample();
      for (int i = 1; i <= 5; i++) begin
         next_cycle();
         redirect_i  = (i == 2);
         redirect_pc = 32'h300;
         sample();
         if (i == 2) begin
            check("coll_grant_req", 32'(imem_req), 32'd1);
            check("coll_head_pc", pc_o, 32'h100);
         end
         if (i == 3) begin
            check("coll_flushed", 32'(instr_valid), 32'd0);
            check("coll_drain_req", 32'(imem_req), 32'd0);
         end
         if (i == 4) check("coll_target_addr", imem_addr, 32'h300);
         if (i == 5) check("coll_stale_dropped", 32'(instr_valid), 32'd0);
      end
      wait_drain("coll_drained", 30);

      // Misaligned target without grant, then wrap-around at the top of memory.
      gnt_mode = 1;
      do_reset();
      gnt_mode    = 0;
      ready       = 1'b1;
      redirect_i  = 1'b1;
      redirect_pc = 32'h203;
      exp_q.push_back(32'h200); exp_q.push_back(32'h204);
      sample();
      check("misalign_old_addr", imem_addr, 32'h100);
      next_cycle();
      redirect_i = 1'b0;
      sample();
      check("misalign_addr", imem_addr, 32'h200);
      wait_drain("misalign_drained", 30);
      next_cycle();
      redirect_i  = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      exp_q.delete();
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
      next_cycle();
      redirect_i = 1'b0;
      wait_drain("wrap_drained", 30);

      // Random latency, grant stalls, decode stalls and redirects.
      gnt_mode = 2; lat_mode = 1;
      do_reset();
      d0 = deliveries;
      exp_tail = 32'h100;
      exp_q.push_back(exp_tail);
      for (int c = 0; c < 800; c++) begin
         if (c != 0) next_cycle();
         ready      = ($urandom_range(0, 9) < 7);
         redirect_i = ($urandom_range(0, 19) == 0);
         if (redirect_i) begin
            tgt = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) tgt = tgt | 32'hFFFF_FFF0;
            redirect_pc = 32'(tgt);
            exp_q.delete();
            exp_tail = {redirect_pc[31:2], 2'b00};
            exp_q.push_back(exp_tail);
         end
         while (exp_q.size() < 6) begin
            exp_tail = exp_tail + 32'd4;
            exp_q.push_back(exp_tail);
         end
      end
      next_cycle();
      ready      = 1'b0;
      redirect_i = 1'b0;
      sample();
      check("rand_progress", 32'((deliveries - d0) >= 30), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
